fir_sequencer: RTL and testbench
================================

Name: fir_sequencer

Overview:
Sequencing FSM for the FIR datapath behind the APB front-end. On a Start edge from the control registers, it takes ownership of the coefficient RAM address mux (FSM_MUX_CDC=0). For each output sample it walks coefficients and input samples, runs a signed multiply-accumulate, and writes the saturated Q15 result to the output sample memory. It drives pracuje and DONE back to the control registers.

Parameters:
COEF_AW, 5, coefficient RAM address width (max 32 taps)
SAMP_AW, 14, sample/result memory address width
DW, 16, sample/coefficient/result width, signed Q15
ACCW, 40, accumulator width (32-bit product + 8 guard bits)

Ports:
clk_b  in  1  single clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
Start  in  1  level from control register; only its rising edge triggers a run
Ile_wsp  in  6  number of taps N; valid range 1..32, values >32 clamp to 32
Ile_probek  in  14  number of samples P
wsp_data  in  DW  coefficient RAM read data; valid 1 cycle after address_FIR
x_data  in  DW  input sample memory read data; valid 1 cycle after x_addr
address_FIR  out  COEF_AW  coefficient RAM read address
FSM_MUX_CDC  out  1  1 = APB owns RAM address; 0 = sequencer owns it
x_addr  out  SAMP_AW  input sample read address
y_addr  out  SAMP_AW  result write address
y_data  out  DW  result write data
y_wr  out  1  result write strobe, 1-cycle pulse
pracuje  out  1  busy
DONE  out  1  run complete, sticky

Behaviour:
- Reset values (immediate, asynchronous): state IDLE, FSM_MUX_CDC=1, pracuje=0, DONE=0, y_wr=0. All addresses, y_data, accumulator and start_q are 0.
- Edge detect: start_q registers Start every cycle. A run is accepted when Start=1, start_q=0 and state=IDLE. A Start held high triggers only one run. Edges seen while not IDLE are ignored and do not queue.
- N_eff = min(Ile_wsp,32). N_eff and P are latched at acceptance; later changes to the inputs do not affect the run in progress.
- If N_eff=0 or P=0 at acceptance: go to FIN. No writes occur, pracuje stays 0, and DONE=1 on the next cycle.
- On acceptance:
  - DONE clears to 0.
  - pracuje and FSM_MUX_CDC=0 take effect in the same edge.
  - n=0, k=0, acc=0.
- States:
  - IDLE.
  - ISSUE: drive address_FIR=k and x_addr=n-k. If n-k<0, set mask bit valid=0 and force x_addr=0. k increments each cycle. After k=N_eff-1, go to DRAIN.
  - DRAIN: 1 cycle; the last product accumulates.
  - WRITE: 1 cycle.
    - y_wr=1, y_addr=n, y_data=sat16(acc>>>15).
    - acc clears to 0 and k to 0.
    - If n=P-1, go to FIN; else n increments and the FSM returns to ISSUE.
  - FIN: 1 cycle. pracuje=0, FSM_MUX_CDC=1, DONE=1, then IDLE.
- MAC pipeline: address in cycle t, data in t+1, then acc += wsp_data*x_data (signed 16x16→32, sign-extended to ACCW). The add is skipped when the delayed valid=0, implementing zero history before x[0].
- Arithmetic: y[n] = sat16(floor(Σ_{k=0}^{N-1} h[k]·x[n-k] / 2^15)). Shift is arithmetic (truncation toward -inf). Saturation bounds are 0x7FFF and 0x8000.
- Timing: pracuje is high exactly P·(N_eff+2)+1 cycles (ISSUE+DRAIN+WRITE per sample, plus FIN). The first y_wr occurs N_eff+1 cycles after acceptance.
- DONE stays 1 until the next accepted run or reset.
- Reset mid-run aborts immediately to reset values. No partial write completes after rst asserts. Start must see a new rising edge after release; a Start held high through reset does not start a run.
- y_wr never asserts outside WRITE. address_FIR/x_addr hold their last value in IDLE.

Test Plan:
- N=1, h0=0x4000, P=3, x=[0x2000,0xE000,0x0001] → y=[0x1000,0xF000,0x0000]; 3 y_wr pulses at y_addr 0,1,2; pracuje high 10 cycles.
- N=2, h=[0x7FFF,0x7FFF], P=2, x=[0x7FFF,0x7FFF] → y0=0x7FFE, y1=0x7FFF (positive saturation); N=1, h=0x8000, x=0x8000 → 0x7FFF.
- N=4, h=[1,2,3,4]<<12, P=3, x=[0x1000,0,0] → y=[0x0200,0x0400,0x0600] (zero-history masking); pracuje 19 cycles; first y_wr 5 cycles after acceptance; FSM_MUX_CDC=0 exactly while pracuje=1.
- Ile_wsp=0 or Ile_probek=0 → no y_wr, pracuje never 1, DONE=1 one cycle after edge; Ile_wsp=40 behaves as 32 (pracuje 34·P+1).
- Start toggled 0→1→0→1 mid-run → ignored, single run. Start held high after FIN → no second run. Ile_wsp changed mid-run → no effect on results.
- rst asserted in cycle 3 of a run → outputs reach reset values immediately. After release with Start still high, no run starts; a new 0→1 edge runs correctly.

Source files
------------

// File: rtl/fir_sequencer.sv
// Sequencer for the FIR datapath: walks taps and samples, runs a signed MAC and
// writes saturated Q15 results, handing the coefficient RAM address mux to APB when idle.
module fir_sequencer #(
  parameter int COEF_AW = 5,
  parameter int SAMP_AW = 14,
  parameter int DW      = 16,
  parameter int ACCW    = 40
) (
  input  logic               clk_b,
  input  logic               rst,
  input  logic               Start,
  input  logic [COEF_AW:0]   Ile_wsp,
  input  logic [SAMP_AW-1:0] Ile_probek,
  input  logic [DW-1:0]      wsp_data,
  input  logic [DW-1:0]      x_data,
  output logic [COEF_AW-1:0] address_FIR,
  output logic               FSM_MUX_CDC,
  output logic [SAMP_AW-1:0] x_addr,
  output logic [SAMP_AW-1:0] y_addr,
  output logic [DW-1:0]      y_data,
  output logic               y_wr,
  output logic               pracuje,
  output logic               DONE
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  localparam logic [COEF_AW:0]        MAX_TAPS = (COEF_AW+1)'(1) << COEF_AW;
  localparam logic signed [ACCW-1:0] SAT_HI   = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO   = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Q15 rescale of the accumulator (arithmetic shift, floor) with saturation to DW bits.
  function automatic logic [DW-1:0] sat_q15(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] s;
    s = v >>> (DW-1);
    if (s > SAT_HI) begin
      sat_q15 = {1'b0, {(DW-1){1'b1}}};
    end else if (s < SAT_LO) begin
      sat_q15 = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_q15 = s[DW-1:0];
    end
  endfunction

  state_t                    state, state_nx;
  logic                      start_q, armed, armed_nx;
  logic [COEF_AW:0]          n_taps, n_taps_nx, n_eff;
  logic [SAMP_AW-1:0]        n_samp, n_samp_nx;
  logic [SAMP_AW-1:0]        n, n_nx;
  logic [COEF_AW-1:0]        k, k_nx, k_inc;
  logic signed [ACCW-1:0]    acc, acc_nx, acc_sum;
  logic signed [2*DW-1:0]    prod;
  logic                      addr_valid, addr_valid_nx, mac_valid;
  logic                      accept, tap_valid;
  logic [COEF_AW-1:0]        address_fir_nx;
  logic [SAMP_AW-1:0]        x_addr_nx, y_addr_nx;
  logic [DW-1:0]             y_data_nx;
  logic                      y_wr_nx, mux_nx, busy_nx, done_nx;

  // Run is armed only after Start has been seen low, so a level held through reset is not an edge.
  assign accept    = Start && !start_q && armed && (state == IDLE);
  assign armed_nx  = armed || !Start;
  assign n_eff     = (Ile_wsp > MAX_TAPS) ? MAX_TAPS : Ile_wsp;
  assign prod      = $signed(wsp_data) * $signed(x_data);
  assign acc_sum   = mac_valid ? (acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod}) : acc;
  assign k_inc     = k + COEF_AW'(1);
  assign tap_valid = (n >= SAMP_AW'(k_inc));

  // Next-state and next-register-value logic.
  always_comb begin
    state_nx       = state;
    n_taps_nx      = n_taps;
    n_samp_nx      = n_samp;
    n_nx           = n;
    k_nx           = k;
    acc_nx         = acc_sum;
    addr_valid_nx  = addr_valid;
    address_fir_nx = address_FIR;
    x_addr_nx      = x_addr;
    y_addr_nx      = y_addr;
    y_data_nx      = y_data;
    y_wr_nx        = 1'b0;
    mux_nx         = FSM_MUX_CDC;
    busy_nx        = pracuje;
    done_nx        = DONE;
    case (state)
      IDLE: begin
        if (accept) begin
          done_nx   = 1'b0;
          n_taps_nx = n_eff;
          n_samp_nx = Ile_probek;
          n_nx      = '0;
          k_nx      = '0;
          acc_nx    = '0;
          if ((n_eff == '0) || (Ile_probek == '0)) begin
            state_nx = FIN;
          end else begin
            state_nx       = ISSUE;
            busy_nx        = 1'b1;
            mux_nx         = 1'b0;
            address_fir_nx = '0;
            x_addr_nx      = '0;
            addr_valid_nx  = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if ({1'b0, k} == (n_taps - (COEF_AW+1)'(1))) begin
          state_nx      = DRAIN;
          addr_valid_nx = 1'b0;
        end else begin
          k_nx           = k_inc;
          address_fir_nx = k_inc;
          x_addr_nx      = tap_valid ? (n - SAMP_AW'(k_inc)) : '0;
          addr_valid_nx  = tap_valid;
        end
      end
      DRAIN: begin
        // The last product lands in acc_sum this cycle, so the result is captured here.
        state_nx  = WRITE;
        y_wr_nx   = 1'b1;
        y_addr_nx = n;
        y_data_nx = sat_q15(acc_sum);
      end
      WRITE: begin
        acc_nx = '0;
        k_nx   = '0;
        if (n == (n_samp - SAMP_AW'(1))) begin
          state_nx = FIN;
        end else begin
          state_nx       = ISSUE;
          n_nx           = n + SAMP_AW'(1);
          address_fir_nx = '0;
          x_addr_nx      = n + SAMP_AW'(1);
          addr_valid_nx  = 1'b1;
        end
      end
      FIN: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        mux_nx   = 1'b1;
        done_nx  = 1'b1;
      end
      default: begin
        state_nx      = IDLE;
        busy_nx       = 1'b0;
        mux_nx        = 1'b1;
        addr_valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      armed       <= 1'b0;
      n_taps      <= '0;
      n_samp      <= '0;
      n           <= '0;
      k           <= '0;
      acc         <= '0;
      addr_valid  <= 1'b0;
      mac_valid   <= 1'b0;
      address_FIR <= '0;
      x_addr      <= '0;
      y_addr      <= '0;
      y_data      <= '0;
      y_wr        <= 1'b0;
      FSM_MUX_CDC <= 1'b1;
      pracuje     <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state       <= state_nx;
      start_q     <= Start;
      armed       <= armed_nx;
      n_taps      <= n_taps_nx;
      n_samp      <= n_samp_nx;
      n           <= n_nx;
      k           <= k_nx;
      acc         <= acc_nx;
      addr_valid  <= addr_valid_nx;
      mac_valid   <= addr_valid;
      address_FIR <= address_fir_nx;
      x_addr      <= x_addr_nx;
      y_addr      <= y_addr_nx;
      y_data      <= y_data_nx;
      y_wr        <= y_wr_nx;
      FSM_MUX_CDC <= mux_nx;
      pracuje     <= busy_nx;
      DONE        <= done_nx;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: memory models, write/busy monitors and a
// direct-convolution reference model.
module tb_fir_sequencer;

  logic        clk_b = 1'b0;
  logic        rst;
  logic        Start;
  logic [5:0]  Ile_wsp;
  logic [13:0] Ile_probek;
  logic [15:0] wsp_data;
  logic [15:0] x_data;
  logic [4:0]  address_FIR;
  logic        FSM_MUX_CDC;
  logic [13:0] x_addr;
  logic [13:0] y_addr;
  logic [15:0] y_data;
  logic        y_wr;
  logic        pracuje;
  logic        DONE;

  fir_sequencer dut (
    .clk_b(clk_b), .rst(rst), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
    .wsp_data(wsp_data), .x_data(x_data), .address_FIR(address_FIR), .FSM_MUX_CDC(FSM_MUX_CDC),
    .x_addr(x_addr), .y_addr(y_addr), .y_data(y_data), .y_wr(y_wr), .pracuje(pracuje), .DONE(DONE)
  );

  always #5 clk_b = ~clk_b;

  logic signed [15:0] h_mem [32];
  logic signed [15:0] x_mem [64];

  always @(posedge clk_b) begin
    wsp_data <= h_mem[address_FIR];
    x_data   <= x_mem[x_addr[5:0]];
  end

  int cyc = 0;
  always @(posedge clk_b) cyc <= cyc + 1;

  int          busy_cnt = 0;
  int          mux_bad  = 0;
  int          wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  always @(negedge clk_b) begin
    if (pracuje === 1'b1) busy_cnt <= busy_cnt + 1;
    if (FSM_MUX_CDC !== ~pracuje) mux_bad <= mux_bad + 1;
    if (y_wr === 1'b1) begin
      wr_addr_q.push_back(int'(y_addr));
      wr_data_q.push_back(y_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y[n] = sat16(floor(sum h[k]*x[n-k] / 2^15)), zero history before x[0].
  function automatic logic [15:0] model_y(input int neff, input int n);
    longint s = 0;
    for (int k = 0; k < neff; k++)
      if (n - k >= 0) s += longint'(h_mem[k]) * longint'(x_mem[n-k]);
    s = s >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic run(input int nw, input int np, input bit mangle);
    int neff, acc_cyc, t, b0, w0, nwr, lim, busy_exp;
    bit zero;
    neff     = (nw > 32) ? 32 : nw;
    zero     = (neff == 0) || (np == 0);
    busy_exp = zero ? 0 : np * (neff + 2) + 1;
    Ile_wsp    = nw[5:0];
    Ile_probek = np[13:0];
    b0 = busy_cnt;
    w0 = wr_addr_q.size();
    @(negedge clk_b);
    Start   = 1'b1;
    acc_cyc = cyc + 1;
    @(negedge clk_b);
    check("done_clear", DONE, 1'b0);
    t = 0;
    if (mangle) begin
      Ile_wsp    = 6'($urandom);
      Ile_probek = 14'($urandom);
      Start = 1'b0; @(negedge clk_b);
      Start = 1'b1; @(negedge clk_b);
      Start = 1'b0; @(negedge clk_b);
      Start = 1'b1;
      t = 3;
    end
    while (DONE !== 1'b1 && t < 5000) begin
      @(negedge clk_b);
      t++;
    end
    check("done_latency", t, zero ? 1 : busy_exp);
    repeat (4) @(negedge clk_b);
    check("done_sticky", DONE, 1'b1);
    check("busy_cycles", busy_cnt - b0, busy_exp);
    check("mux_vs_busy", mux_bad, 0);
    nwr = wr_addr_q.size() - w0;
    check("write_count", nwr, zero ? 0 : np);
    lim = (nwr < np) ? nwr : np;
    for (int i = 0; i < lim; i++) begin
      check($sformatf("y_addr[%0d]", i), wr_addr_q[w0+i], i);
      check($sformatf("y_data[%0d]", i), wr_data_q[w0+i], model_y(neff, i));
    end
    if (nwr > 0) check("first_wr_latency", wr_cyc_q[w0] - acc_cyc, neff + 1);
    Start = 1'b0;
    @(negedge clk_b);
  endtask

  initial begin
    int b0;
    rst = 1'b1; Start = 1'b0; Ile_wsp = 6'd0; Ile_probek = 14'd0;
    for (int i = 0; i < 32; i++) h_mem[i] = 16'sd0;
    for (int i = 0; i < 64; i++) x_mem[i] = 16'sd0;
    repeat (2) @(negedge clk_b);
    check("rst_mux", FSM_MUX_CDC, 1'b1);
    check("rst_busy", pracuje, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_ywr", y_wr, 1'b0);
    check("rst_ydata", y_data, 16'h0000);
    rst = 1'b0;
    @(negedge clk_b);

    h_mem[0] = 16'sh4000;
    x_mem[0] = 16'sh2000; x_mem[1] = 16'shE000; x_mem[2] = 16'sh0001;
    run(1, 3, 1'b0);
    check("tp1_y1_const", wr_data_q[wr_data_q.size()-2], 16'hF000);

    h_mem[0] = 16'sh7FFF; h_mem[1] = 16'sh7FFF;
    x_mem[0] = 16'sh7FFF; x_mem[1] = 16'sh7FFF;
    run(2, 2, 1'b0);
    check("pos_sat_const", wr_data_q[wr_data_q.size()-1], 16'h7FFF);
    h_mem[0] = 16'sh8000; x_mem[0] = 16'sh8000;
    run(1, 1, 1'b0);

    for (int i = 0; i < 4; i++) h_mem[i] = 16'(i + 1) <<< 12;
    x_mem[0] = 16'sh1000; x_mem[1] = 16'sh0000; x_mem[2] = 16'sh0000;
    run(4, 3, 1'b1);
    check("mask_y2_const", wr_data_q[wr_data_q.size()-1], 16'h0600);

    run(0, 5, 1'b0);
    run(3, 0, 1'b0);

    for (int i = 0; i < 32; i++) h_mem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) x_mem[i] = 16'($urandom);
    run(40, 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) h_mem[i] = 16'($urandom);
      for (int i = 0; i < 64; i++) x_mem[i] = 16'($urandom);
      run(int'($urandom_range(1, 8)), int'($urandom_range(1, 12)), r[0]);
    end

    Ile_wsp = 6'd4; Ile_probek = 14'd3;
    @(negedge clk_b);
    Start = 1'b1;
    repeat (3) @(negedge clk_b);
    check("pre_rst_busy", pracuje, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", pracuje, 1'b0);
    check("mid_rst_mux", FSM_MUX_CDC, 1'b1);
    check("mid_rst_done", DONE, 1'b0);
    check("mid_rst_ywr", y_wr, 1'b0);
    check("mid_rst_addr", address_FIR, 5'd0);
    check("mid_rst_xaddr", x_addr, 14'd0);
    @(negedge clk_b);
    rst = 1'b0;
    b0 = busy_cnt;
    repeat (10) @(negedge clk_b);
    check("held_start_no_run", busy_cnt - b0, 0);
    check("held_start_done", DONE, 1'b0);
    Start = 1'b0;
    @(negedge clk_b);
    run(4, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
